// File: rtl/linked_list_pkg.sv
// -----------------------------------------------------------------------------
// linked_list package
// Shared constants and types for the linked-list engine. The head table uses:
//   LL_BUCKET_WIDTH    default bucket address width
//   LL_HEAD_PTR_WIDTH  default head pointer width
//   ll_head_entry_t    one head-table entry {ptr_val, ptr}
//   ll_head_state_t    head-table controller state (INIT sweep / RUN)
// No ports.
// -----------------------------------------------------------------------------
package linked_list;

   localparam int LL_BUCKET_WIDTH   = 10;
   localparam int LL_HEAD_PTR_WIDTH = 16;

   typedef struct packed {
      logic                         ptr_val;
      logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
   } ll_head_entry_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ll_head_state_t;

endpackage

// File: rtl/ll_head_table_if.sv
// -----------------------------------------------------------------------------
// ll_head_if
// Bundles the head-table traffic between the list manager / search datapath
// (master) and ll_head_table (slave).
//   clear_req           master->slave  restart the initialisation sweep
//   init_done           slave->master  table initialised, accepting traffic
//   wr_addr/wr_data_ptr/wr_data_ptr_val/wr_en
//                       master->slave  head write, no backpressure
//   rd_req_addr/rd_req_val
//                       master->slave  lookup request
//   rd_req_ready        slave->master  lookup accepted when val && ready
//   rd_resp_val/rd_resp_ptr/rd_resp_ptr_val
//                       slave->master  lookup response, 2 cycles after accept
//   err_wr_during_init  slave->master  sticky, write seen before init_done
// -----------------------------------------------------------------------------
interface ll_head_if
   import linked_list::*;
#(
   parameter int BUCKET_WIDTH = LL_BUCKET_WIDTH,
   parameter int PTR_WIDTH    = LL_HEAD_PTR_WIDTH
);

   logic                    clear_req;
   logic                    init_done;
   logic [BUCKET_WIDTH-1:0] wr_addr;
   logic [PTR_WIDTH-1:0]    wr_data_ptr;
   logic                    wr_data_ptr_val;
   logic                    wr_en;
   logic [BUCKET_WIDTH-1:0] rd_req_addr;
   logic                    rd_req_val;
   logic                    rd_req_ready;
   logic                    rd_resp_val;
   logic [PTR_WIDTH-1:0]    rd_resp_ptr;
   logic                    rd_resp_ptr_val;
   logic                    err_wr_during_init;

   modport slave (
      input  clear_req,
      input  wr_addr,
      input  wr_data_ptr,
      input  wr_data_ptr_val,
      input  wr_en,
      input  rd_req_addr,
      input  rd_req_val,
      output init_done,
      output rd_req_ready,
      output rd_resp_val,
      output rd_resp_ptr,
      output rd_resp_ptr_val,
      output err_wr_during_init
   );

   modport master (
      output clear_req,
      output wr_addr,
      output wr_data_ptr,
      output wr_data_ptr_val,
      output wr_en,
      output rd_req_addr,
      output rd_req_val,
      input  init_done,
      input  rd_req_ready,
      input  rd_resp_val,
      input  rd_resp_ptr,
      input  rd_resp_ptr_val,
      input  err_wr_during_init
   );

endinterface

// File: rtl/ll_head_table_ram.sv
// -----------------------------------------------------------------------------
// ll_head_ram
// Generic simple dual-port RAM, one write port and one registered read port,
// written so it maps onto a block RAM. Read-during-write to the same address
// returns the old contents.
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable; o_rdata holds when low
//   i_raddr  read address
//   o_rdata  read data, one cycle after i_re
// -----------------------------------------------------------------------------
module ll_head_ram #(
   parameter int WIDTH  = 17,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [2**ADDR_W];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ll_head_table.sv
// -----------------------------------------------------------------------------
// ll_head_table
// Bucket-indexed head-pointer store. After reset or clear_req it sweeps every
// bucket to {0,0} (one per cycle), then accepts head writes and serves
// fixed-latency (2 cycle) pipelined lookups, one per cycle.
//   clk      sole clock
//   rst      synchronous, active-high reset
//   io_head  ll_head_if.slave: clear_req, init_done, write port
//            (wr_addr/wr_data_ptr/wr_data_ptr_val/wr_en), lookup request
//            (rd_req_addr/rd_req_val/rd_req_ready), lookup response
//            (rd_resp_val/rd_resp_ptr/rd_resp_ptr_val), err_wr_during_init
// Build option:
//   LL_HEAD_TABLE_BYPASS_EN  defined   -> same-cycle same-address write is
//                                         forwarded to the lookup (write-first)
//                            undefined -> lookup sees old contents (read-first)
// -----------------------------------------------------------------------------
module ll_head_table
   import linked_list::*;
#(
   parameter int BUCKET_WIDTH = LL_BUCKET_WIDTH,
   parameter int PTR_WIDTH    = LL_HEAD_PTR_WIDTH
) (
   input  logic    clk,
   input  logic    rst,
   ll_head_if.slave io_head
);

   localparam int                      ENTRY_W   = PTR_WIDTH + 1;
   localparam logic [BUCKET_WIDTH-1:0] LAST_ADDR = {BUCKET_WIDTH{1'b1}};

   ll_head_state_t          r_state;
   ll_head_state_t          w_state_nxt;
   logic [BUCKET_WIDTH-1:0] r_cnt;
   logic [BUCKET_WIDTH-1:0] w_cnt_nxt;
   logic                    w_run;

   logic                    w_usr_we;
   logic                    w_ram_we;
   logic [BUCKET_WIDTH-1:0] w_ram_waddr;
   logic [ENTRY_W-1:0]      w_wr_entry;
   logic [ENTRY_W-1:0]      w_ram_wdata;
   logic                    w_rd_acc;
   logic [ENTRY_W-1:0]      w_ram_rdata;
   logic [ENTRY_W-1:0]      w_rd_entry_p1;

   logic                    r_vld_p1;
   logic                    r_resp_val_p2;
   logic [ENTRY_W-1:0]      r_resp_entry_p2;
   logic                    r_err;

   // Controller: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Controller: next state. clear_req in either state restarts the sweep.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         INIT: begin
            if (io_head.clear_req) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LAST_ADDR) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RUN: begin
            if (io_head.clear_req) begin
               w_state_nxt = INIT;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_run                = (r_state == RUN);
   assign io_head.init_done    = w_run;
   assign io_head.rd_req_ready = w_run;

   // The single RAM write port is owned by the sweep in INIT and by the list
   // manager in RUN; user writes arriving in INIT are dropped and flagged.
   assign w_usr_we    = io_head.wr_en && w_run;
   assign w_wr_entry  = {io_head.wr_data_ptr_val, io_head.wr_data_ptr};
   assign w_ram_we    = !w_run || w_usr_we;
   assign w_ram_waddr = w_run ? io_head.wr_addr : r_cnt;
   assign w_ram_wdata = w_run ? w_wr_entry : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (io_head.wr_en && !w_run) begin
         r_err <= 1'b1;
      end
   end

   assign io_head.err_wr_during_init = r_err;

   assign w_rd_acc = io_head.rd_req_val && w_run;

   // Stage p0 -> p1: registered RAM read
   ll_head_ram #(
      .WIDTH  (ENTRY_W),
      .ADDR_W (BUCKET_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_re    (w_rd_acc),
      .i_raddr (io_head.rd_req_addr),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= w_rd_acc;
      end
   end

`ifdef LL_HEAD_TABLE_BYPASS_EN
   // The RAM is read-first, so a write landing on the looked-up bucket in the
   // same cycle is captured here and substituted at the output stage.
   logic               r_fwd_hit_p1;
   logic [ENTRY_W-1:0] r_fwd_data_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_hit_p1 <= 1'b0;
      end else begin
         r_fwd_hit_p1 <= w_rd_acc && w_usr_we &&
                         (io_head.wr_addr == io_head.rd_req_addr);
      end
      if (w_rd_acc) begin
         r_fwd_data_p1 <= w_wr_entry;
      end
   end

   assign w_rd_entry_p1 = r_fwd_hit_p1 ? r_fwd_data_p1 : w_ram_rdata;
`else
   assign w_rd_entry_p1 = w_ram_rdata;
`endif

   // Stage p1 -> p2: output register; data holds between responses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_val_p2   <= 1'b0;
         r_resp_entry_p2 <= '0;
      end else begin
         r_resp_val_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_resp_entry_p2 <= w_rd_entry_p1;
         end
      end
   end

   assign io_head.rd_resp_val     = r_resp_val_p2;
   assign io_head.rd_resp_ptr_val = r_resp_entry_p2[PTR_WIDTH];
   assign io_head.rd_resp_ptr     = r_resp_entry_p2[PTR_WIDTH-1:0];

endmodule
